// File: rtl/gsim_param.sv
// -----------------------------------------------------------------------------
// gsim_param -- parametrised Gauss-Seidel solver for an N-unknown banded system
//
//   20*x_i - 13*(x_{i-1}+x_{i+1}) + 6*(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) = b_i
//
// A job has three phases:
//   RECEIVE  the N integer offsets b_0..b_{N-1} arrive serially on b_in.
//   CALC     ITER in-place sweeps run, one unknown updated per clock.
//   SEND     x_0..x_{N-1} are streamed out on x_out.
//
// Parameters
//   N     number of unknowns (4..64)
//   B_W   width of each signed offset b_i
//   X_W   width of each signed fixed-point result x_i
//   FRAC  fractional bits of x_i (format Q(X_W-FRAC).FRAC)
//   ITER  sweeps per job (1..255)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-high; aborts any job in progress
//   in_en      b_in carries a valid offset this cycle
//   b_in       signed offset, delivered in index order 0..N-1
//   busy       high while in CALC or SEND
//   out_valid  x_out carries a valid result this cycle (registered)
//   x_out      signed fixed-point result, delivered in index order 0..N-1
//
// Optional build macro GSIM_CONVERGE_EN adds:
//   tol        input, X_W bits unsigned; a sweep whose largest update
//              magnitude is <= tol ends the job early (ITER stays the bound)
//   iter_used  output, 8 bits; number of sweeps run, valid with out_valid
//
// Handshake: in_en and out_valid are valid-only strobes with no ready. The
// solver is implicitly ready whenever it is in RECEIVE and drops in_en
// beats on the floor in CALC and SEND; the consumer of x_out must accept
// every out_valid beat because there is no backpressure.
//
// The FSM state, element index and sweep count are the registers `state`,
// `idx` and `sweep`.
// -----------------------------------------------------------------------------
module gsim_param #(
  parameter int N    = 16,
  parameter int B_W  = 16,
  parameter int X_W  = 32,
  parameter int FRAC = 16,
  parameter int ITER = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [B_W-1:0] b_in,
  output logic           busy,
  output logic           out_valid,
  output logic [X_W-1:0] x_out
`ifdef GSIM_CONVERGE_EN
  ,
  input  logic [X_W-1:0] tol,
  output logic [7:0]     iter_used
`endif
);

  localparam int IW = $clog2(N);

  // The row sum needs X_W+6 bits for the neighbour terms; the shifted offset
  // needs B_W+FRAC bits on its own, which can exceed X_W (e.g. a narrow
  // X_W with a full 16-bit offset). Size the sum for whichever is larger so
  // that nothing wraps before the saturation stage.
  localparam int BSW = B_W + FRAC;
  localparam int SW  = ((BSW > X_W) ? BSW : X_W) + 6;

  localparam logic [1:0] S_RECEIVE = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;

  localparam logic [IW-1:0] LAST       = IW'(N - 1);
  localparam logic [7:0]    LAST_SWEEP = 8'(ITER - 1);

  localparam logic signed [SW-1:0] C1  = SW'(1);
  localparam logic signed [SW-1:0] C6  = SW'(6);
  localparam logic signed [SW-1:0] C13 = SW'(13);
  localparam logic signed [SW-1:0] C20 = SW'(20);

  // Saturation bounds of a signed X_W value, expressed at sum width.
  localparam logic signed [SW-1:0] X_MAX =
    $signed({{(SW - X_W + 1){1'b0}}, {(X_W - 1){1'b1}}});
  localparam logic signed [SW-1:0] X_MIN =
    $signed({{(SW - X_W + 1){1'b1}}, {(X_W - 1){1'b0}}});

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [7:0]    sweep;

  // Working storage; neither array is reset. b is fully rewritten by every
  // job and x is cleared when the last offset of a job arrives.
  logic signed [X_W-1:0] x [N];
  logic signed [B_W-1:0] b [N];

  function automatic logic signed [SW-1:0] sx(input logic signed [X_W-1:0] v);
    return {{(SW - X_W){v[X_W-1]}}, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Neighbour fetch for the unknown being updated (i = idx).
  // Each neighbour is picked by comparing every array slot against i+k, so an
  // index outside 0..N-1 simply matches nothing and contributes zero.
  // Because x is updated in place, x[i-1..i-3] already hold this sweep's
  // values and x[i+1..i+3] still hold the previous sweep's values.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] xm1, xm2, xm3, xp1, xp2, xp3;

  always_comb begin
    xm1 = '0;
    xm2 = '0;
    xm3 = '0;
    xp1 = '0;
    xp2 = '0;
    xp3 = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx) - 1) xm1 = sx(x[j]);
      if (j == int'(idx) - 2) xm2 = sx(x[j]);
      if (j == int'(idx) - 3) xm3 = sx(x[j]);
      if (j == int'(idx) + 1) xp1 = sx(x[j]);
      if (j == int'(idx) + 2) xp2 = sx(x[j]);
      if (j == int'(idx) + 3) xp3 = sx(x[j]);
    end
  end

  // ---------------------------------------------------------------------------
  // Row update: S = (b_i << FRAC) + 13*(x-1 + x+1) - 6*(x-2 + x+2) + (x-3 + x+3)
  // then x_i = saturate(floor(S / 20)).
  // ---------------------------------------------------------------------------
  logic signed [B_W-1:0] b_sel;
  logic signed [SW-1:0]  b_term;
  logic signed [SW-1:0]  s_sum;
  logic signed [SW-1:0]  q_trunc;
  logic signed [SW-1:0]  r_trunc;
  logic signed [SW-1:0]  q_floor;
  logic signed [X_W-1:0] x_new;

  always_comb begin
    b_sel   = b[idx];
    b_term  = $signed({{(SW - B_W){b_sel[B_W-1]}}, b_sel}) <<< FRAC;
    s_sum   = b_term + C13 * (xm1 + xp1) - C6 * (xm2 + xp2) + (xm3 + xp3);
    // Signed division truncates toward zero; a negative sum with a non-zero
    // remainder must step one further down to round toward -infinity.
    q_trunc = s_sum / C20;
    r_trunc = s_sum % C20;
    if (r_trunc != '0 && s_sum[SW-1]) begin
      q_floor = q_trunc - C1;
    end else begin
      q_floor = q_trunc;
    end
    if (q_floor > X_MAX) begin
      x_new = X_MAX[X_W-1:0];
    end else if (q_floor < X_MIN) begin
      x_new = X_MIN[X_W-1:0];
    end else begin
      x_new = q_floor[X_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Early-exit detection
  // ---------------------------------------------------------------------------
  logic converged;

`ifdef GSIM_CONVERGE_EN
  // Largest |x_new - x_old| seen so far in the current sweep. At the first
  // element of a sweep the running maximum restarts from that element alone.
  logic [SW-1:0]        max_d;
  logic signed [SW-1:0] diff;
  logic [SW-1:0]        abs_d;
  logic [SW-1:0]        sweep_max;

  always_comb begin
    diff  = sx(x_new) - sx(x[idx]);
    abs_d = diff[SW-1] ? $unsigned(-diff) : $unsigned(diff);
    if (idx == '0) begin
      sweep_max = abs_d;
    end else if (abs_d > max_d) begin
      sweep_max = abs_d;
    end else begin
      sweep_max = max_d;
    end
    converged = (sweep_max <= {{(SW - X_W){1'b0}}, tol});
  end
`else
  assign converged = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and output registers
  // ---------------------------------------------------------------------------
  assign busy = (state != S_RECEIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RECEIVE;
      idx       <= '0;
      sweep     <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
`ifdef GSIM_CONVERGE_EN
      max_d     <= '0;
      iter_used <= '0;
`endif
    end else begin
      case (state)
        S_RECEIVE: begin
          out_valid <= 1'b0;
          if (in_en) begin
            if (idx == LAST) begin
              idx   <= '0;
              sweep <= '0;
              state <= S_CALC;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_CALC: begin
`ifdef GSIM_CONVERGE_EN
          max_d <= sweep_max;
`endif
          if (idx == LAST) begin
            idx <= '0;
            // The sweep that just finished is the last one either because
            // the budget is spent or because it moved nothing beyond tol.
            if (sweep == LAST_SWEEP || converged) begin
              state <= S_SEND;
`ifdef GSIM_CONVERGE_EN
              iter_used <= sweep + 8'd1;
`endif
            end else begin
              sweep <= sweep + 8'd1;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end

        S_SEND: begin
          out_valid <= 1'b1;
          x_out     <= x[idx];
          // Leaving on the beat that carries x_{N-1}: out_valid is still high
          // for that beat and falls on the next edge, taken in RECEIVE.
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_RECEIVE;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        default: begin
          state <= S_RECEIVE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Array storage (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == S_RECEIVE && in_en) begin
      b[idx] <= b_in;
      // The final offset of a job also starts every unknown from zero.
      if (idx == LAST) begin
        for (int j = 0; j < N; j++) begin
          x[j] <= '0;
        end
      end
    end else if (state == S_CALC) begin
      x[idx] <= x_new;
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// -----------------------------------------------------------------------------
// tb_gsim_param -- bench for gsim_param
//
// Three solver instances share one input stream:
//   d0  defaults (N=16, X_W=32, FRAC=16, ITER=16)
//   d1  ITER=1
//   d2  X_W=24, ITER=4 (narrow result, exercises saturation)
// Each job's expected results come from a plain-arithmetic Gauss-Seidel
// model; a negedge process compares every output beat, latency and busy.
// -----------------------------------------------------------------------------
module tb_gsim_param;

  localparam int N    = 16;
  localparam int FRAC = 16;
  localparam int ND   = 3;

`ifdef GSIM_CONVERGE_EN
  localparam bit CONV_EN = 1'b1;
`else
  localparam bit CONV_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic [31:0] tol;

  logic        busy0, busy1, busy2;
  logic        ov0, ov1, ov2;
  logic [31:0] xo0, xo1;
  logic [23:0] xo2;
`ifdef GSIM_CONVERGE_EN
  logic [7:0]  iu0, iu1, iu2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gsim_param #(.N(16), .B_W(16), .X_W(32), .FRAC(16), .ITER(16)) u_d0 (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .busy(busy0), .out_valid(ov0), .x_out(xo0)
`ifdef GSIM_CONVERGE_EN
    , .tol(tol), .iter_used(iu0)
`endif
  );

  gsim_param #(.N(16), .B_W(16), .X_W(32), .FRAC(16), .ITER(1)) u_d1 (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .busy(busy1), .out_valid(ov1), .x_out(xo1)
`ifdef GSIM_CONVERGE_EN
    , .tol(tol), .iter_used(iu1)
`endif
  );

  gsim_param #(.N(16), .B_W(16), .X_W(24), .FRAC(16), .ITER(4)) u_d2 (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
    .busy(busy2), .out_valid(ov2), .x_out(xo2)
`ifdef GSIM_CONVERGE_EN
    , .tol(tol[23:0]), .iter_used(iu2)
`endif
  );

  // ---------------------------------------------------------------------------
  // Per-instance accessors
  // ---------------------------------------------------------------------------
  function automatic int iter_of(input int d);
    case (d)
      0:       return 16;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int xw_of(input int d);
    return (d == 2) ? 24 : 32;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return (d == 2) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [31:0] get_x(input int d);
    case (d)
      0:       return xo0;
      1:       return xo1;
      default: return {8'h00, xo2};
    endcase
  endfunction

`ifdef GSIM_CONVERGE_EN
  function automatic int get_used(input int d);
    case (d)
      0:       return int'(iu0);
      1:       return int'(iu1);
      default: return int'(iu2);
    endcase
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  int n_checks = 0;
  int n_pass   = 0;
  int last_edge = -1000000;
  int used_exp[ND];
  bit prev_ov[ND];

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic void qpush(input int d, input logic [31:0] v);
    case (d)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic logic [31:0] qpop(input int d);
    case (d)
      0:       return exp_q0.pop_front();
      1:       return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: textbook Gauss-Seidel on a plain array of integers.
  // ---------------------------------------------------------------------------
  function automatic longint xa(input longint xv[$], input int k);
    if (k < 0 || k >= N) return 0;
    return xv[k];
  endfunction

  function automatic void golden(input longint bq[$], input int iter, input int xw,
                                 input longint tl, output longint xr[$], output int used);
    longint xv[$];
    longint s, q, hi, lo, dl, dmax;
    xv = {};
    for (int i = 0; i < N; i++) xv.push_back(0);
    hi = (longint'(1) <<< (xw - 1)) - 1;
    lo = -(longint'(1) <<< (xw - 1));
    used = 0;
    for (int sw = 0; sw < iter; sw++) begin
      dmax = 0;
      for (int i = 0; i < N; i++) begin
        s = bq[i] * (longint'(1) <<< FRAC)
            + 13 * (xa(xv, i - 1) + xa(xv, i + 1))
            - 6  * (xa(xv, i - 2) + xa(xv, i + 2))
            +      (xa(xv, i - 3) + xa(xv, i + 3));
        q = s / 20;
        if ((s % 20) != 0 && s < 0) q = q - 1;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        dl = q - xv[i];
        if (dl < 0) dl = -dl;
        if (dl > dmax) dmax = dl;
        xv[i] = q;
      end
      used = sw + 1;
      if (CONV_EN && dmax <= tl) break;
    end
    xr = xv;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        prev_ov[d] = 1'b0;
        while (qsize(d) != 0) void'(qpop(d));
      end else begin
        logic ov;
        logic [31:0] e;
        ov = get_ov(d);
        chk($sformatf("busy d%0d", d), longint'(get_busy(d)),
            longint'(cyc >= last_edge && cyc < last_edge + used_exp[d] * N + N));
        if (ov) begin
          if (!prev_ov[d])
            chk($sformatf("latency d%0d", d), cyc - last_edge, used_exp[d] * N + 1);
          if (qsize(d) == 0) begin
            chk($sformatf("unexpected out_valid d%0d", d), 1, 0);
          end else begin
            e = qpop(d);
            chk($sformatf("x_out d%0d", d), longint'(get_x(d)), longint'(e));
          end
`ifdef GSIM_CONVERGE_EN
          chk($sformatf("iter_used d%0d", d), get_used(d), used_exp[d]);
`endif
        end else if (prev_ov[d] && qsize(d) != 0) begin
          chk($sformatf("out_valid burst d%0d", d), qsize(d), 0);
        end
        prev_ov[d] = ov;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic start_job(input longint bq[$]);
    longint xr[$];
    int u;
    last_edge = -1000000;
    for (int d = 0; d < ND; d++) begin
      golden(bq, iter_of(d), xw_of(d), longint'(tol & mask_of(d)), xr, u);
      used_exp[d] = u;
      for (int i = 0; i < N; i++) qpush(d, 32'(xr[i]) & mask_of(d));
    end
    // Offsets with random stall cycles carrying junk on b_in.
    for (int i = 0; i < N; i++) begin
      bit go;
      go = 1'b0;
      while (!go) begin
        @(negedge clk);
        go    = ($urandom_range(0, 1) == 1);
        in_en = go;
        b_in  = go ? 16'(bq[i]) : 16'($urandom);
      end
      if (i == N - 1) last_edge = cyc + 1;
    end
    // Junk while every instance is computing; none of it may be stored.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      in_en = ($urandom_range(0, 1) == 1);
      b_in  = 16'($urandom);
    end
    @(negedge clk);
    in_en = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((qsize(0) + qsize(1) + qsize(2) != 0 || busy0 || busy1 || busy2) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("job drained within budget", longint'(t < 4000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_job(input longint bq[$]);
    start_job(bq);
    wait_done();
  endtask

  function automatic void make_const(input longint v, output longint bq[$]);
    bq = {};
    for (int i = 0; i < N; i++) bq.push_back(v);
  endfunction

  function automatic void make_impulse(input longint v, output longint bq[$]);
    bq = {};
    bq.push_back(v);
    for (int i = 1; i < N; i++) bq.push_back(0);
  endfunction

  function automatic void make_rand(output longint bq[$]);
    bq = {};
    for (int i = 0; i < N; i++) bq.push_back(longint'($signed(16'($urandom))));
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s out_valid d%0d", tag, d), longint'(get_ov(d)), 0);
      chk($sformatf("%s busy d%0d", tag, d), longint'(get_busy(d)), 0);
      chk($sformatf("%s x_out d%0d", tag, d), longint'(get_x(d)), 0);
`ifdef GSIM_CONVERGE_EN
      chk($sformatf("%s iter_used d%0d", tag, d), get_used(d), 0);
`endif
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    longint bq[$];
    longint xr[$];
    int u;

    reset = 1'b0;
    in_en = 1'b0;
    b_in  = '0;
    tol   = '0;
    for (int d = 0; d < ND; d++) used_exp[d] = 0;
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Hand-computed values that pin the model itself.
    make_impulse(20, bq);
    golden(bq, 1, 32, 0, xr, u);
    chk("model x0 impulse+", xr[0], 65536);
    chk("model x1 impulse+", xr[1], 42598);
    chk("model x2 impulse+", xr[2], 8027);
    chk("model x3 impulse+", xr[3], -4286);
    make_impulse(-20, bq);
    golden(bq, 1, 32, 0, xr, u);
    chk("model x0 impulse-", xr[0], -65536);
    chk("model x1 impulse-", xr[1], -42599);
    make_const(32767, bq);
    golden(bq, 4, 24, 0, xr, u);
    chk("model x0 saturate", xr[0], 8388607);
    make_const(0, bq);
    golden(bq, 16, 32, 0, xr, u);
    chk("model sweeps zero b", u, CONV_EN ? 1 : 16);

    // Directed jobs.
    make_impulse(20, bq);
    run_job(bq);
    make_impulse(-20, bq);
    run_job(bq);
    make_const(32767, bq);
    run_job(bq);
    make_const(-32768, bq);
    run_job(bq);
    make_const(0, bq);
    run_job(bq);

    // Random jobs.
    for (int j = 0; j < 4; j++) begin
      make_rand(bq);
      run_job(bq);
    end

    // Abort the default instance around sweep 5, then rerun cleanly.
    make_rand(bq);
    start_job(bq);
    repeat (5 * N - 13) @(negedge clk);
    #2 reset = 1'b1;
    last_edge = -1000000;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    make_rand(bq);
    run_job(bq);
    make_const(0, bq);
    run_job(bq);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
